psum_accumulator: RTL and testbench

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

---
 rtl/psum_accumulator.sv | 181 ++++++++++++++++++
 tb/tb_psum_accumulator.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums PE-group partial sums per window, adds bias, rounds,
// shifts and saturates to int8 on one or two lanes. Optional ReLU via PSUM_ACC_RELU_EN.

module psum_lane #(
    parameter int ACC_W  = 32,
    parameter int BIAS_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add_en,
    input  logic              load_out,
    input  logic              zero_out,
    input  logic [17:0]       groupsum,
    input  logic [BIAS_W-1:0] bias,
    input  logic [4:0]        shift,
    output logic [7:0]        ofmap
);
    localparam int AB_W = (ACC_W > BIAS_W) ? ACC_W : BIAS_W;
    // Wide enough for acc+bias and the largest rounding constant (2^30) with no overflow.
    localparam int VW   = ((AB_W > 32) ? AB_W : 32) + 2;
    localparam logic signed [VW-1:0] SAT_HI = VW'(127);
    localparam logic signed [VW-1:0] SAT_LO = -VW'(128);

    logic signed [ACC_W-1:0] acc;
    logic signed [VW-1:0]    v, rnd, vs, vr;
    logic signed [7:0]       sat, res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (add_en)
            acc <= acc + {{(ACC_W-18){groupsum[17]}}, groupsum};
    end

    always_comb begin
        v   = {{(VW-ACC_W){acc[ACC_W-1]}}, acc} + {{(VW-BIAS_W){bias[BIAS_W-1]}}, bias};
        rnd = (shift != 5'd0) ? (VW'(1) << (shift - 5'd1)) : '0;
        vs  = v + rnd;
        vr  = vs >>> shift;
        if (vr > SAT_HI)
            sat = 8'sd127;
        else if (vr < SAT_LO)
            sat = -8'sd128;
        else
            sat = vr[7:0];
`ifdef PSUM_ACC_RELU_EN
        res = sat[7] ? 8'sd0 : sat;
`else
        res = sat;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ofmap <= '0;
        else if (load_out)
            ofmap <= zero_out ? 8'd0 : res;
    end
endmodule

module psum_accumulator #(
    parameter int ACC_W  = 32,
    parameter int BIAS_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        layer,
    input  logic              start,
    input  logic [7:0]        acc_len,
    input  logic [BIAS_W-1:0] bias_in,
    input  logic [4:0]        shift,
    input  logic              in_valid,
    input  logic [17:0]       groupsum_in1,
    input  logic [17:0]       groupsum_in2,
    output logic [7:0]        ofmap_out1,
    output logic [7:0]        ofmap_out2,
    output logic              out_valid,
    output logic              busy
);
    localparam int NUM_LANES = 2;

    typedef enum logic [1:0] {IDLE, ACC, POST} state_t;

    state_t state, state_nxt;
    logic   layer_ok, clr, acc_fire, post_fire;
    logic   single_q;
    logic [7:0]        len_q, cnt;
    logic [BIAS_W-1:0] bias_q;
    logic [4:0]        shift_q;

    logic [NUM_LANES-1:0][17:0] gsum;
    logic [NUM_LANES-1:0][7:0]  ofmap;

    assign layer_ok = (layer == 4'd1) || (layer == 4'd3) || (layer == 4'd4);
    assign gsum     = {groupsum_in2, groupsum_in1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        clr       = 1'b0;
        acc_fire  = 1'b0;
        post_fire = 1'b0;
        case (state)
            IDLE: begin
                if (start && layer_ok) begin
                    clr       = 1'b1;
                    state_nxt = ACC;
                end
            end
            ACC: begin
                busy = 1'b1;
                if (in_valid) begin
                    acc_fire = 1'b1;
                    if ((cnt + 8'd1) == len_q)
                        state_nxt = POST;
                end
            end
            POST: begin
                busy      = 1'b1;
                post_fire = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Window configuration is captured at start so inputs may change mid-window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            single_q <= 1'b0;
            len_q    <= 8'd1;
            bias_q   <= '0;
            shift_q  <= '0;
            cnt      <= '0;
        end else if (clr) begin
            single_q <= (layer == 4'd1);
            len_q    <= (acc_len == 8'd0) ? 8'd1 : acc_len;
            bias_q   <= bias_in;
            shift_q  <= shift;
            cnt      <= '0;
        end else if (acc_fire) begin
            cnt <= cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_valid <= 1'b0;
        else
            out_valid <= post_fire;
    end

    // Lane 0 always runs; upper lanes are idle and forced to zero in single-lane mode.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        psum_lane #(.ACC_W(ACC_W), .BIAS_W(BIAS_W)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .add_en   (acc_fire && ((i == 0) || !single_q)),
            .load_out (post_fire),
            .zero_out ((i != 0) && single_q),
            .groupsum (gsum[i]),
            .bias     (bias_q),
            .shift    (shift_q),
            .ofmap    (ofmap[i])
        );
    end

    assign ofmap_out1 = ofmap[0];
    assign ofmap_out2 = ofmap[1];
endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator; expectations follow PSUM_ACC_RELU_EN when defined.
module tb_psum_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  layer = '0;
    logic        start = 1'b0;
    logic [7:0]  acc_len = '0;
    logic [15:0] bias_in = '0;
    logic [4:0]  shift = '0;
    logic        in_valid = 1'b0;
    logic [17:0] groupsum_in1 = '0, groupsum_in2 = '0;
    logic [7:0]  ofmap_out1, ofmap_out2;
    logic        out_valid, busy;

    psum_accumulator #(.ACC_W(32), .BIAS_W(16)) dut (
        .clk(clk), .rst(rst), .layer(layer), .start(start), .acc_len(acc_len),
        .bias_in(bias_in), .shift(shift), .in_valid(in_valid),
        .groupsum_in1(groupsum_in1), .groupsum_in2(groupsum_in2),
        .ofmap_out1(ofmap_out1), .ofmap_out2(ofmap_out2),
        .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] o1; logic [7:0] o2; } exp_t;
    exp_t sbq[$];
    int   n_tests = 0, n_fail = 0;

    bit     win_on = 0;
    int     w_len, w_cnt, w_layer, w_bias, w_shift;
    longint s1, s2;
    logic [7:0] last1 = '0, last2 = '0;

    function automatic logic [7:0] rl(int v);
`ifdef PSUM_ACC_RELU_EN
        if (v < 0) return 8'd0;
`endif
        return 8'(v);
    endfunction

    function automatic logic [7:0] model(longint acc, int b, int sh);
        longint v;
        v = acc + longint'(b);
        if (sh > 0) v = (v + (longint'(1) <<< (sh - 1))) >>> sh;
        if (v > 127) v = 127;
        else if (v < -128) v = -128;
        return rl(int'(v));
    endfunction

    // Output monitor: pops one expectation per out_valid, checks hold otherwise.
    always @(negedge clk) begin
        if (rst) begin
            last1 = '0; last2 = '0;
        end else if (out_valid) begin
            n_tests++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out_valid got %0d/%0d, expected no output",
                         $signed(ofmap_out1), $signed(ofmap_out2));
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if ({ofmap_out1, ofmap_out2} !== {e.o1, e.o2}) begin
                    n_fail++;
                    $display("FAIL ofmap got %0d/%0d expected %0d/%0d", $signed(ofmap_out1),
                             $signed(ofmap_out2), $signed(e.o1), $signed(e.o2));
                end
            end
            last1 = ofmap_out1; last2 = ofmap_out2;
        end else begin
            n_tests++;
            if ({ofmap_out1, ofmap_out2} !== {last1, last2}) begin
                n_fail++;
                $display("FAIL ofmap_hold got %0d/%0d expected %0d/%0d", $signed(ofmap_out1),
                         $signed(ofmap_out2), $signed(last1), $signed(last2));
            end
        end
    end

    task automatic idle(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic expect_out(int a, int b);
        exp_t e;
        e.o1 = rl(a); e.o2 = rl(b);
        sbq.push_back(e);
    endtask

    task automatic start_win(int l, int len, int b, int sh);
        layer = 4'(l); acc_len = 8'(len); bias_in = 16'(b); shift = 5'(sh); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        win_on  = (l == 1 || l == 3 || l == 4);
        w_len   = (len == 0) ? 1 : len;
        w_cnt   = 0; w_layer = l; w_bias = b; w_shift = sh; s1 = 0; s2 = 0;
    endtask

    task automatic send(int a, int b);
        groupsum_in1 = 18'(a); groupsum_in2 = 18'(b); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (win_on) begin
            s1 += a;
            if (w_layer != 1) s2 += b;
            w_cnt++;
            if (w_cnt == w_len) begin
                exp_t e;
                e.o1 = model(s1, w_bias, w_shift);
                e.o2 = (w_layer == 1) ? 8'd0 : model(s2, w_bias, w_shift);
                sbq.push_back(e);
                win_on = 0;
            end
        end
    endtask

    task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        #2;
        chk("reset_out_valid", 8'(out_valid), 8'd0);
        chk("reset_busy", 8'(busy), 8'd0);
        chk("reset_out1", ofmap_out1, 8'd0);
        chk("reset_out2", ofmap_out2, 8'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(1);
    endtask

    task automatic test_basic();
        start_win(3, 3, 0, 0); win_on = 0;
        expect_out(60, -15);
        send(10, -5); send(20, -5); send(30, -5);
        chk("lat_post_valid", 8'(out_valid), 8'd0);
        chk("lat_post_busy", 8'(busy), 8'd1);
        layer = 4'd3; acc_len = 8'd1; start = 1'b1;   // lands on the POST edge
        @(posedge clk); #1;
        start = 1'b0;
        chk("lat_out_valid", 8'(out_valid), 8'd1);
        chk("post_start_ignored_busy", 8'(busy), 8'd0);
        idle(1);
        chk("out_valid_one_cycle", 8'(out_valid), 8'd0);
        idle(2);
    endtask

    task automatic test_saturate();
        start_win(1, 1, 0, 2); win_on = 0;
        expect_out(127, 0);
        send(1000, 500); idle(3);
        start_win(3, 1, 0, 0); win_on = 0;
        expect_out(-128, 127);
        send(-1000, 131071); idle(3);
    endtask

    task automatic test_round();
        start_win(3, 1, 0, 2); win_on = 0;
        expect_out(2, -1);
        send(6, -6); idle(2);
        start_win(3, 1, -20, 2); win_on = 0;
        expect_out(-5, -5);
        send(0, 0); idle(2);
        start_win(4, 1, 0, 1); win_on = 0;
        expect_out(2, -1);
        send(3, -3); idle(2);
    endtask

    task automatic test_gaps();
        start_win(4, 4, 0, 0); win_on = 0;
        expect_out(10, 0);
        send(1, 0); idle(2);
        send(2, 0);
        layer = 4'd3; acc_len = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idle(1);
        send(3, 0); idle(2);
        send(4, 0); idle(6);
    endtask

    task automatic test_reset_mid();
        start_win(3, 3, 0, 0); win_on = 0;
        send(5, 5); send(5, 5);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", 8'(busy), 8'd0);
        chk("async_rst_out1", ofmap_out1, 8'd0);
        @(posedge clk); #1 rst = 1'b0;
        send(5, 5); idle(4);
        chk("rst_mid_busy", 8'(busy), 8'd0);
        start_win(3, 3, 0, 0); win_on = 0;
        expect_out(21, 3);
        send(7, 1); send(7, 1); send(7, 1); idle(3);
    endtask

    task automatic test_bad_layer();
        int bad [3] = '{2, 0, 15};
        foreach (bad[k]) begin
            start_win(bad[k], 2, 0, 0);
            chk("bad_layer_busy", 8'(busy), 8'd0);
            send(50, 50); send(50, 50); idle(3);
            chk("bad_layer_busy_after", 8'(busy), 8'd0);
        end
        start_win(1, 1, 0, 0); win_on = 0;
        expect_out(3, 0);
        send(3, 9); idle(3);
    endtask

    task automatic test_len_bounds();
        start_win(3, 0, 0, 0); win_on = 0;
        expect_out(-7, 9);
        send(-7, 9); idle(3);
        start_win(3, 255, 0, 20); win_on = 0;
        expect_out(32, -32);
        for (int i = 0; i < 255; i++) send(131071, -131072);
        idle(3);
    endtask

    task automatic test_back_to_back();
        int lays [3] = '{1, 3, 4};
        for (int w = 0; w < 24; w++) begin
            int len;
            len = int'($urandom_range(6, 1));
            start_win(lays[$urandom_range(2)], len, int'($urandom_range(4000)) - 2000,
                      int'($urandom_range(12)));
            for (int i = 0; i < len; i++) begin
                send(int'($urandom_range(4000)) - 2000, int'($urandom_range(4000)) - 2000);
                if ($urandom_range(1) == 1 && i != len - 1) idle(1);
            end
            idle(1);
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_round();
        test_gaps();
        test_reset_mid();
        test_bad_layer();
        test_len_bounds();
        test_back_to_back();
        idle(10);
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL missing_outputs got %0d pending expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
